// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Two-stage pipelined integer ALU with valid/ready handshakes on both sides.
//   Stage 1 captures the operands, opcode and tag. Stage 2 holds the computed
//   result, its status flags and the tag, and drives the outputs directly.
//   One operation per cycle is sustained, and full backpressure is supported.
//
// Parameters
//   WIDTH  operand/result width in bits (2..64)
//   TAG_W  width of the opaque tag carried with each operation (1..16)
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  upstream handshake
//   in_a, in_b, in_op    operands and 3-bit opcode
//   in_tag               tag, returned unchanged with the result
//   out_valid/out_ready  downstream handshake
//   out_result, out_tag  result and its tag
//   out_zero             result is zero
//   out_carry, out_ovf   adder carry-out / signed overflow (ADD and SUB only)
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_SLT   = 3'b010;
    localparam logic [2:0] OP_SLTU  = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
    } alu_res_t;

    // One shared adder serves ADD, SUB and both compares. The compares ride
    // the subtract path: SLTU is "borrow occurred", SLT is the sign of the
    // difference corrected by overflow.
    function automatic alu_res_t alu_eval(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        alu_res_t         r;
        logic             use_sub;
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH:0]   sum;
        logic             ovf;

        use_sub = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
        b_eff   = use_sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, use_sub};
        ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

        r.result = '0;
        r.carry  = 1'b0;
        r.ovf    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                r.result = sum[WIDTH-1:0];
                r.carry  = sum[WIDTH];
                r.ovf    = ovf;
            end
            OP_SLT:  r.result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            OP_SLTU: r.result = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
            OP_AND:  r.result = a & b;
            OP_OR:   r.result = a | b;
            OP_XOR:  r.result = a ^ b;
            default: r.result = b;   // OP_PASSB
        endcase
        return r;
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [2:0]       op_p1;
    logic [TAG_W-1:0] tag_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] result_p2;
    logic [TAG_W-1:0] tag_p2;
    logic             zero_p2;
    logic             carry_p2;
    logic             ovf_p2;

    logic             s2_adv;
    logic             acc_in;
    logic             adv_s1;
    alu_res_t         res_p1;

    // A stage can take new data when it is empty or its content leaves in
    // the same cycle; this chains back so a full pipe never bubbles.
    assign s2_adv   = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_adv;
    assign acc_in   = in_valid && in_ready;
    assign adv_s1   = vld_p1 && s2_adv;

    always_comb begin
        res_p1 = alu_eval(op_p1, a_p1, b_p1);
    end

    // ---- Stage 1: operand capture on input handshake ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_in) begin
            a_p1   <= in_a;
            b_p1   <= in_b;
            op_p1  <= in_op;
            tag_p1 <= in_tag;
        end
    end

    // ---- Stage 2: result, flags and tag; drives the outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            tag_p2    <= '0;
            zero_p2   <= 1'b0;
            carry_p2  <= 1'b0;
            ovf_p2    <= 1'b0;
        end else begin
            if (s2_adv) begin
                vld_p2 <= vld_p1;
            end
            if (adv_s1) begin
                result_p2 <= res_p1.result;
                tag_p2    <= tag_p1;
                zero_p2   <= (res_p1.result == '0);
                carry_p2  <= res_p1.carry;
                ovf_p2    <= res_p1.ovf;
            end
        end
    end

    assign out_valid  = vld_p2;
    assign out_result = result_p2;
    assign out_tag    = tag_p2;
    assign out_zero   = zero_p2;
    assign out_carry  = carry_p2;
    assign out_ovf    = ovf_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
//   Bench for alu_pipe. A 32-bit/4-bit-tag instance takes the directed vector
//   table, the reset, throughput and backpressure sequences; an 8-bit/3-bit-tag
//   instance takes randomised handshakes. Expected results are queued when an
//   operation is accepted and popped when the DUT delivers a result.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_SLT   = 3'b010;
    localparam logic [2:0] OP_SLTU  = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef struct packed {
        logic [63:0] r;
        logic [15:0] tag;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    logic clk;
    logic rst_n;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] in_a32, in_b32, out_result32;
    logic [2:0]  in_op32;
    logic [3:0]  in_tag32, out_tag32;
    logic        out_zero32, out_carry32, out_ovf32;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  in_a8, in_b8, out_result8;
    logic [2:0]  in_op8;
    logic [2:0]  in_tag8, out_tag8;
    logic        out_zero8, out_carry8, out_ovf8;

    alu_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .in_a(in_a32), .in_b(in_b32), .in_op(in_op32), .in_tag(in_tag32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .out_result(out_result32), .out_tag(out_tag32),
        .out_zero(out_zero32), .out_carry(out_carry32), .out_ovf(out_ovf32)
    );

    alu_pipe #(.WIDTH(8), .TAG_W(3)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_op(in_op8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_result(out_result8), .out_tag(out_tag8),
        .out_zero(out_zero8), .out_carry(out_carry8), .out_ovf(out_ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests;
    int   n_fail;
    exp_t q32[$];
    exp_t q8[$];
    exp_t pend32, pend8;
    bit   mon_en;
    bit   acc32, acc8;
    bit   seen_in_ready32, seen_out_valid32;
    bit   stall32, stall8;
    logic [39:0] snap32;
    logic [14:0] snap8;
    int   n_out32, n_out8, n_acc8;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: plain wide integer arithmetic, signed values
    // obtained by subtracting 2^w from negative encodings.
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [63:0] mask;
        logic [64:0] s;
        longint      sa, sb, sr, lo, hi;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a);
        sb = longint'(b);
        if (a[w-1]) sa = sa - longint'(64'd1 << w);
        if (b[w-1]) sb = sb - longint'(64'd1 << w);
        hi = longint'(64'd1 << (w - 1)) - 1;
        lo = -longint'(64'd1 << (w - 1));
        e = '0;
        case (op)
            OP_ADD: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[63:0] & mask;
                e.c = s[w];
                sr  = sa + sb;
                e.v = (sr < lo) || (sr > hi);
            end
            OP_SUB: begin
                e.r = (a - b) & mask;
                e.c = (a >= b);
                sr  = sa - sb;
                e.v = (sr < lo) || (sr > hi);
            end
            OP_SLT:  e.r = (sa < sb) ? 64'd1 : 64'd0;
            OP_SLTU: e.r = (a < b) ? 64'd1 : 64'd0;
            OP_AND:  e.r = a & b;
            OP_OR:   e.r = a | b;
            OP_XOR:  e.r = a ^ b;
            default: e.r = b;
        endcase
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    // One clock: at the falling edge compare delivered results and stall
    // stability, record acceptances, then return just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (mon_en && rst_n) begin
            if (stall32)
                check("stall_hold32",
                      64'({out_valid32, out_tag32, out_zero32, out_carry32, out_ovf32, out_result32}),
                      64'(snap32));
            if (stall8)
                check("stall_hold8",
                      64'({out_valid8, out_tag8, out_zero8, out_carry8, out_ovf8, out_result8}),
                      64'(snap8));
            if (out_valid32 && out_ready32) begin
                n_out32++;
                n_tests++;
                if (q32.size() == 0) begin
                    n_fail++;
                    $display("FAIL out32_unexpected: result 0x%0h tag %0d with nothing pending",
                             out_result32, out_tag32);
                end else begin
                    e = q32.pop_front();
                    if (out_result32 !== e.r[31:0] || out_tag32 !== e.tag[3:0] ||
                        out_zero32 !== e.z || out_carry32 !== e.c || out_ovf32 !== e.v) begin
                        n_fail++;
                        $display("FAIL out32: got r=%h t=%0d z%b c%b v%b, want r=%h t=%0d z%b c%b v%b",
                                 out_result32, out_tag32, out_zero32, out_carry32, out_ovf32,
                                 e.r[31:0], e.tag[3:0], e.z, e.c, e.v);
                    end
                end
            end
            if (out_valid8 && out_ready8) begin
                n_out8++;
                n_tests++;
                if (q8.size() == 0) begin
                    n_fail++;
                    $display("FAIL out8_unexpected: result 0x%0h tag %0d with nothing pending",
                             out_result8, out_tag8);
                end else begin
                    e = q8.pop_front();
                    if (out_result8 !== e.r[7:0] || out_tag8 !== e.tag[2:0] ||
                        out_zero8 !== e.z || out_carry8 !== e.c || out_ovf8 !== e.v) begin
                        n_fail++;
                        $display("FAIL out8: got r=%h t=%0d z%b c%b v%b, want r=%h t=%0d z%b c%b v%b",
                                 out_result8, out_tag8, out_zero8, out_carry8, out_ovf8,
                                 e.r[7:0], e.tag[2:0], e.z, e.c, e.v);
                    end
                end
            end
        end
        stall32 = out_valid32 && !out_ready32;
        stall8  = out_valid8 && !out_ready8;
        snap32  = {out_valid32, out_tag32, out_zero32, out_carry32, out_ovf32, out_result32};
        snap8   = {out_valid8, out_tag8, out_zero8, out_carry8, out_ovf8, out_result8};
        seen_in_ready32  = in_ready32;
        seen_out_valid32 = out_valid32;
        acc32 = in_valid32 && in_ready32;
        acc8  = in_valid8 && in_ready8;
        if (acc32) q32.push_back(pend32);
        if (acc8) begin
            q8.push_back(pend8);
            n_acc8++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, input exp_t e);
        in_op32    = op;
        in_a32     = a;
        in_b32     = b;
        in_tag32   = tag;
        pend32     = e;
        pend32.tag = 16'(tag);
        in_valid32 = 1'b1;
    endtask

    task automatic send32();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!acc32 && k < 50);
        if (!acc32) check("send32_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        in_valid32  = 1'b0;
        in_valid8   = 1'b0;
        out_ready32 = 1'b1;
        out_ready8  = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (q32.size() == 0 && q8.size() == 0) break;
            tick();
        end
        repeat (3) tick();
        check("drain_q32_empty", 64'(q32.size()), 64'd0);
        check("drain_q8_empty", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        vec_t        tbl[14];
        exp_t        e;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          i, c, out_base;
        bit          saw_full;

        tbl[0]  = '{OP_ADD,   32'h00000005, 32'h00000007, 4'h1, 32'h0000000C, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{OP_ADD,   32'hFFFFFFFF, 32'h00000001, 4'h2, 32'h00000000, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 4'h3, 32'h80000000, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{OP_SUB,   32'h00000003, 32'h00000005, 4'h4, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{OP_SUB,   32'h00000005, 32'h00000005, 4'h5, 32'h00000000, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{OP_SUB,   32'h80000000, 32'h00000001, 4'h6, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{OP_SLT,   32'hFFFFFFFF, 32'h00000001, 4'h7, 32'h00000001, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 4'h8, 32'h00000000, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{OP_SLT,   32'h80000000, 32'h7FFFFFFF, 4'h9, 32'h00000001, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{OP_SLTU,  32'h80000000, 32'h7FFFFFFF, 4'hA, 32'h00000000, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 4'hB, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 4'hC, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 4'hD, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{OP_PASSB, 32'hF0F0F0F0, 32'hFF00FF00, 4'hE, 32'hFF00FF00, 1'b0, 1'b0, 1'b0};

        n_tests = 0; n_fail = 0; mon_en = 1'b0;
        n_out32 = 0; n_out8 = 0; n_acc8 = 0;
        stall32 = 1'b0; stall8 = 1'b0;
        rst_n = 1'b0;
        in_valid32 = 1'b0; in_a32 = '0; in_b32 = '0; in_op32 = '0; in_tag32 = '0; out_ready32 = 1'b1;
        in_valid8  = 1'b0; in_a8  = '0; in_b8  = '0; in_op8  = '0; in_tag8  = '0; out_ready8  = 1'b1;
        pend32 = '0; pend8 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_out_result", 64'(out_result32), 64'd0);
        check("rst_out_tag", 64'(out_tag32), 64'd0);
        check("rst_flags", 64'({out_zero32, out_carry32, out_ovf32}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready32), 64'd1);

        // One op in flight, valid held high, then an asynchronous reset
        in_op32 = OP_ADD; in_a32 = 32'd5; in_b32 = 32'd7; in_tag32 = 4'd3; in_valid32 = 1'b1;
        @(posedge clk); #1;
        check("lat_not_yet", 64'(out_valid32), 64'd0);
        @(posedge clk); #1;
        check("lat_out_valid", 64'(out_valid32), 64'd1);
        check("lat_result", 64'(out_result32), 64'd12);
        check("lat_tag", 64'(out_tag32), 64'd3);
        check("lat_flags", 64'({out_zero32, out_carry32, out_ovf32}), 64'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid32), 64'd0);
        check("async_rst_result", 64'(out_result32), 64'd0);
        in_valid32 = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_stale_after_rst", 64'(out_valid32), 64'd0);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Directed vector table, back to back
        for (int t = 0; t < 14; t++) begin
            e = '0;
            e.r = 64'(tbl[t].r);
            e.z = tbl[t].z; e.c = tbl[t].c; e.v = tbl[t].v;
            drive32(tbl[t].op, tbl[t].a, tbl[t].b, tbl[t].tag, e);
            send32();
        end
        drain();

        // Full throughput: 16 ops with both handshakes held high
        for (int t = 0; t < 16; t++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            drive32(op, a, b, 4'(t), model(32, op, 64'(a), 64'(b)));
            tick();
            check("tput_in_ready", 64'(seen_in_ready32), 64'd1);
            check("tput_accept", 64'(acc32), 64'd1);
            if (t >= 2) check("tput_out_valid", 64'(seen_out_valid32), 64'd1);
        end
        drain();

        // Backpressure: 8 ops, tags 0..7, out_ready low during cycles 3..6
        out_base = n_out32;
        saw_full = 1'b0;
        i = 0;
        c = 0;
        while (i < 8 && c < 60) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            drive32(op, a, b, 4'(i), model(32, op, 64'(a), 64'(b)));
            out_ready32 = !(c >= 3 && c <= 6);
            tick();
            if (!seen_in_ready32) saw_full = 1'b1;
            if (acc32) i++;
            c++;
        end
        check("bp_all_accepted", 64'(i), 64'd8);
        check("bp_in_ready_dropped", 64'(saw_full), 64'd1);
        drain();
        check("bp_results_count", 64'(n_out32 - out_base), 64'd8);

        // Randomised handshakes on the 8-bit instance
        for (int t = 0; t < 400; t++) begin
            in_valid8  = 1'($urandom_range(0, 1));
            out_ready8 = 1'($urandom_range(0, 1));
            in_op8  = 3'($urandom_range(0, 7));
            in_a8   = 8'($urandom);
            in_b8   = 8'($urandom);
            in_tag8 = 3'($urandom);
            pend8     = model(8, in_op8, 64'(in_a8), 64'(in_b8));
            pend8.tag = 16'(in_tag8);
            tick();
        end
        drain();
        check("rand_count", 64'(n_out8), 64'(n_acc8));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit combinational add/sub/compare ALU.
- Generalises operand width and adds a full operation set, including signed and unsigned compare and logic ops.
- Produces status flags and carries a tag through the pipe.
- Two register stages with valid/ready handshakes on both sides. Throughput is one operation per cycle under full backpressure support.
- Sits between the issue logic (upstream) and the writeback/result bus (downstream).

Parameters:
- WIDTH, 32, operand/result width in bits (legal: 2..64).
- TAG_W, 4, width of the opaque tag carried alongside each operation (legal: 1..16).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  block can accept an operation this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode.
- in_tag  input  TAG_W  tag; returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  result.
- out_tag  output  TAG_W  tag of this result.
- out_zero  output  1  out_result == 0.
- out_carry  output  1  carry-out of the adder (ADD/SUB only, else 0).
- out_ovf  output  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1.
  - 010 SLT: signed A<B, zero-extended to WIDTH.
  - 011 SLTU: unsigned A<B, zero-extended to WIDTH.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 PASSB: result = B.
- Arithmetic:
  - Single shared WIDTH+1-bit adder; SUB inverts B and sets carry-in to 1.
  - Result is truncated to WIDTH (wrap-around mod 2^WIDTH).
  - out_carry is bit WIDTH of the sum. For SUB, 1 means no borrow (A>=B unsigned).
  - out_ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff is B for ADD and ~B for SUB.
  - SLTU = ~carry of the subtract path. SLT = sub_msb XOR sub_ovf.
- Stage 1 (S1) registers in_a, in_b, in_op, in_tag and s1_valid on an input handshake (in_valid && in_ready).
- Stage 2 (S2) registers the computed result, flags, tag and s2_valid from S1. out_* are driven directly from S2 registers.
- Latency: an operation accepted at edge N appears on out_* after edge N+1 (two edges from accept, no stall).
- Stall rules:
  - s2_adv = !s2_valid || out_ready.
  - S1 moves into S2 when s2_adv.
  - in_ready = !s1_valid || s2_adv. in_ready has no combinational dependence on in_valid.
- Simultaneous accept and drain on either stage must proceed in the same cycle; there are no bubbles at full throughput.
- When a stage is stalled, its registers hold value. The outputs stay stable while out_valid && !out_ready.
- Data registers update only on a handshake. Reset only clears the valid bits and out_* flags.
- Reset:
  - Asynchronous on rst_n low: s1_valid=0, s2_valid=0, out_result=0, out_tag=0, all flags 0.
  - in_ready=1 once rst_n is high.
  - In-flight operations are discarded when reset asserts mid-operation.
- out_valid is never asserted for an operation that was not accepted. Each accepted operation is emitted exactly once, in order.

Test Plan:
- Reset release, then one in-flight op: in_valid held 1 and out_ready=1; ADD A=5,B=7,tag=3 -> after the 2nd edge, out_valid=1, result=12, tag=3, zero=0, carry=0, ovf=0. Then assert rst_n low mid-flight -> out_valid=0 immediately (asynchronous), no stale output after release.
- Arithmetic edges (WIDTH=32), each -> required outputs:
  - ADD FFFFFFFF+1 -> result 0, zero=1, carry=1, ovf=0.
  - ADD 7FFFFFFF+1 -> result 80000000, ovf=1.
  - SUB 3-5 -> result FFFFFFFE, carry=0.
  - SUB 5-5 -> zero=1, carry=1.
- Compares:
  - SLT A=FFFFFFFF, B=1 -> 1.
  - SLTU same operands -> 0.
  - SLT A=80000000, B=7FFFFFFF -> 1.
  - SLTU same operands -> 0.
  - Logic ops AND/OR/XOR/PASSB on A=F0F0F0F0, B=FF00FF00 -> F000F000 / FFF0FFF0 / 0FF00FF0 / FF00FF00.
- Backpressure: stream 8 ops with tags 0..7, out_ready=0 for cycles 3..6 -> in_ready drops once both stages are full; out_* stable while stalled; all 8 results arrive in order with no loss or duplication.
- Full throughput: in_valid=1 and out_ready=1 continuously for 16 ops -> one result per cycle after 2-cycle fill; in_ready stays 1 throughout.
- Randomised handshake toggling on in_valid/out_ready with WIDTH=8, TAG_W=3 vs. a reference model queue -> every result, flag and tag matches the model in order.
